// File: rtl/ctrl_reg_arbiter_if.sv
// Write-request bus shared by the two requesters of ctrl_reg_arbiter.
// Port A carries validated SPI frames and port B carries sequencer or test-host writes.
// Each port is a valid/ready handshake with a 7-bit address and 8-bit data.
interface ctrl_reg_arbiter_if;
  logic       a_valid;
  logic [6:0] a_addr;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [6:0] b_addr;
  logic [7:0] b_data;
  logic       b_ready;

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready
  );
endinterface

// File: rtl/ctrl_reg_arbiter.sv
// Control register bank with a two-port round-robin write arbiter.
// The bank holds output enables, PWM enables and the PWM duty cycle.
// After reset, INIT loads the parameterised defaults one per cycle.
// IDLE grants one requester and latches its request.
// COMMIT applies the latched write or rejects it, then returns to IDLE.
// A lock bit that only port A can write blocks all port B writes.
module ctrl_reg_arbiter #(
  parameter logic [7:0] DEF_OUT_LO = 8'h00,
  parameter logic [7:0] DEF_OUT_HI = 8'h00,
  parameter logic [7:0] DEF_PWM_LO = 8'h00,
  parameter logic [7:0] DEF_PWM_HI = 8'h00,
  parameter logic [7:0] DEF_DUTY   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_reg_arbiter_if.slave bus,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              lock,
  output logic              wr_done,
  output logic              wr_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [2:0] LAST_INIT_IDX = 3'd4;
  localparam logic [6:0] LOCK_ADDR     = 7'h05;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] init_cnt;
  logic       last_b;

  logic       grant_a;
  logic       grant_b;

  logic [6:0] req_addr_p1;
  logic [7:0] req_data_p1;
  logic       req_b_p1;

  logic       bank_we;
  logic [2:0] bank_idx;
  logic [7:0] bank_val;
  logic       commit_ok;
  logic       commit_err;

  // Reset default for bank entry idx; idx values outside 0..4 never reach this path.
  function automatic logic [7:0] def_value(input logic [2:0] idx);
    case (idx)
      3'd0:    def_value = DEF_OUT_LO;
      3'd1:    def_value = DEF_OUT_HI;
      3'd2:    def_value = DEF_PWM_LO;
      3'd3:    def_value = DEF_PWM_HI;
      3'd4:    def_value = DEF_DUTY;
      default: def_value = 8'h00;
    endcase
  endfunction

  // A write is rejected for an unmapped address, for a port B write to the lock register,
  // or for any port B write while the lock is set.
  function automatic logic is_rejected(input logic [6:0] addr, input logic from_b,
                                       input logic lk);
    is_rejected = (addr > LOCK_ADDR) || (from_b && (addr == LOCK_ADDR)) || (from_b && lk);
  endfunction

  // Next-state, arbitration and bank write selection.
  always_comb begin
    state_nxt  = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    bank_we    = 1'b0;
    bank_idx   = 3'd0;
    bank_val   = 8'h00;
    commit_ok  = 1'b0;
    commit_err = 1'b0;
    case (state)
      INIT: begin
        bank_we  = 1'b1;
        bank_idx = init_cnt;
        bank_val = def_value(init_cnt);
        if (init_cnt == LAST_INIT_IDX) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        // When both ports are valid, grant the port that was not granted last.
        if (bus.a_valid && (!bus.b_valid || last_b)) begin
          grant_a = 1'b1;
        end else if (bus.b_valid) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
        if (is_rejected(req_addr_p1, req_b_p1, lock)) begin
          commit_err = 1'b1;
        end else begin
          commit_ok = 1'b1;
          bank_we   = 1'b1;
          bank_idx  = req_addr_p1[2:0];
          bank_val  = req_data_p1;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Control: init counter, round-robin pointer and the one-cycle result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= 3'd0;
      last_b   <= 1'b1;
      wr_done  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_done <= commit_ok;
      wr_err  <= commit_err;
      if (state == INIT) begin
        init_cnt <= init_cnt + 3'd1;
      end
      if (grant_a) begin
        last_b <= 1'b0;
      end else if (grant_b) begin
        last_b <= 1'b1;
      end
    end
  end

  // Grant -> commit boundary: latch the granted request for evaluation in COMMIT.
  always_ff @(posedge clk) begin
    if (grant_a || grant_b) begin
      req_addr_p1 <= grant_a ? bus.a_addr : bus.b_addr;
      req_data_p1 <= grant_a ? bus.a_data : bus.b_data;
      req_b_p1    <= grant_b;
    end
  end

  // Register bank and lock bit, written from INIT defaults or accepted commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
      lock            <= 1'b0;
    end else if (bank_we) begin
      case (bank_idx)
        3'd0:    en_reg_out_7_0  <= bank_val;
        3'd1:    en_reg_out_15_8 <= bank_val;
        3'd2:    en_reg_pwm_7_0  <= bank_val;
        3'd3:    en_reg_pwm_15_8 <= bank_val;
        3'd4:    pwm_duty_cycle  <= bank_val;
        3'd5:    lock            <= bank_val[0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_reg_arbiter.sv
// Self-checking bench for ctrl_reg_arbiter.
// Directed scenarios are followed by randomized two-port traffic.
// A transaction-level model tracks the expected register contents, lock state and round-robin order.
module tb_ctrl_reg_arbiter;

  localparam logic [7:0] T_DEF_DUTY = 8'h80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_reg_arbiter_if bus();

  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic       lock, wr_done, wr_err, busy;

  ctrl_reg_arbiter #(
    .DEF_OUT_LO(8'h00),
    .DEF_OUT_HI(8'h00),
    .DEF_PWM_LO(8'h00),
    .DEF_PWM_HI(8'h00),
    .DEF_DUTY  (T_DEF_DUTY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .en_reg_out_7_0 (out_lo),
    .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0 (pwm_lo),
    .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle (duty),
    .lock           (lock),
    .wr_done        (wr_done),
    .wr_err         (wr_err),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_reg [0:4];
  logic       m_lock;
  logic       m_last_b;

  // Pending requests per port; each is held until granted.
  logic       pa_v, pb_v;
  logic [6:0] pa_addr, pb_addr;
  logic [7:0] pa_data, pb_data;

  function automatic logic [7:0] def_of(input int i);
    return (i == 4) ? T_DEF_DUTY : 8'h00;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_bank(input string when);
    check_val({when, "_out_lo"}, 32'(out_lo), 32'(m_reg[0]));
    check_val({when, "_out_hi"}, 32'(out_hi), 32'(m_reg[1]));
    check_val({when, "_pwm_lo"}, 32'(pwm_lo), 32'(m_reg[2]));
    check_val({when, "_pwm_hi"}, 32'(pwm_hi), 32'(m_reg[3]));
    check_val({when, "_duty"},   32'(duty),   32'(m_reg[4]));
    check_val({when, "_lock"},   32'(lock),   32'(m_lock));
  endtask

  // Apply one write to the model and report whether the write is rejected.
  task automatic model_commit(input logic from_b, input logic [6:0] addr,
                              input logic [7:0] data, output logic rej);
    rej = (addr > 7'd5) || (from_b && (addr == 7'd5)) || (from_b && m_lock);
    if (!rej) begin
      if (addr == 7'd5) m_lock = data[0];
      else m_reg[addr[2:0]] = data;
    end
  endtask

  // Enter with the clock at a negedge: assert reset, hold both valids high and walk through INIT.
  task automatic do_reset();
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 7'h02; bus.a_data = 8'h3C;
    bus.b_valid = 1'b1; bus.b_addr = 7'h03; bus.b_data = 8'hC3;
    pa_v = 1'b0; pb_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val("init_busy",    32'(busy),        32'd1);
      check_val("init_a_ready", 32'(bus.a_ready), 32'd0);
      check_val("init_b_ready", 32'(bus.b_ready), 32'd0);
      check_val("init_wr_done", 32'(wr_done),     32'd0);
      check_val("init_wr_err",  32'(wr_err),      32'd0);
      check_val("init_out_lo",  32'(out_lo),      32'd0);
      check_val("init_duty",    32'(duty),        32'd0);
      @(negedge clk);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    for (int i = 0; i < 5; i++) m_reg[i] = def_of(i);
    m_lock   = 1'b0;
    m_last_b = 1'b1;
    check_val("post_init_busy", 32'(busy), 32'd0);
    check_bank("defaults");
  endtask

  // Enter at an IDLE negedge: present the pending requests and check arbitration.
  // If a request is granted, follow it through COMMIT to the result pulse.
  // The task returns at the next IDLE negedge.
  task automatic step();
    logic       ga, gb, rej, from_b;
    logic [6:0] ad;
    logic [7:0] dt;
    bus.a_valid = pa_v; bus.a_addr = pa_addr; bus.a_data = pa_data;
    bus.b_valid = pb_v; bus.b_addr = pb_addr; bus.b_data = pb_data;
    #1;
    ga = pa_v && (!pb_v || m_last_b);
    gb = pb_v && !ga;
    check_val("idle_busy",    32'(busy),        32'd0);
    check_val("idle_a_ready", 32'(bus.a_ready), 32'(ga));
    check_val("idle_b_ready", 32'(bus.b_ready), 32'(gb));
    @(negedge clk);
    if (!ga && !gb) begin
      check_val("quiet_wr_done", 32'(wr_done), 32'd0);
      check_val("quiet_wr_err",  32'(wr_err),  32'd0);
      return;
    end
    from_b   = gb;
    ad       = gb ? pb_addr : pa_addr;
    dt       = gb ? pb_data : pa_data;
    m_last_b = gb;
    if (ga) begin pa_v = 1'b0; bus.a_valid = 1'b0; end
    else    begin pb_v = 1'b0; bus.b_valid = 1'b0; end
    check_val("commit_busy",    32'(busy),    32'd1);
    check_val("commit_wr_done", 32'(wr_done), 32'd0);
    check_val("commit_wr_err",  32'(wr_err),  32'd0);
    check_bank("commit_hold");
    #1;
    check_val("commit_a_ready", 32'(bus.a_ready), 32'd0);
    check_val("commit_b_ready", 32'(bus.b_ready), 32'd0);
    @(negedge clk);
    model_commit(from_b, ad, dt, rej);
    check_val("wr_done", 32'(wr_done), 32'(!rej));
    check_val("wr_err",  32'(wr_err),  32'(rej));
    check_bank("after_commit");
  endtask

  task automatic set_a(input logic [6:0] addr, input logic [7:0] data);
    pa_v = 1'b1; pa_addr = addr; pa_data = data;
  endtask

  task automatic set_b(input logic [6:0] addr, input logic [7:0] data);
    pb_v = 1'b1; pb_addr = addr; pb_data = data;
  endtask

  task automatic rand_req(input logic port_b);
    int         r;
    logic [6:0] addr;
    logic [7:0] data;
    r    = int'($urandom_range(0, 15));
    addr = (r < 12) ? 7'(r % 6) : 7'($urandom_range(6, 127));
    data = 8'($urandom);
    if (port_b) set_b(addr, data);
    else set_a(addr, data);
  endtask

  initial begin
    pa_v = 1'b0; pb_v = 1'b0;
    pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
    do_reset();

    // Both ports continuously valid: grants alternate starting with A.
    set_a(7'h00, 8'h11);
    set_b(7'h01, 8'h22);
    for (int i = 0; i < 6; i++) begin
      step();
      if (!pa_v) set_a(7'h00, 8'h11);
      if (!pb_v) set_b(7'h01, 8'h22);
    end
    pa_v = 1'b0;
    step();
    check_val("rr_out_lo", 32'(out_lo), 32'h11);
    check_val("rr_out_hi", 32'(out_hi), 32'h22);

    // Single write from A.
    set_a(7'h02, 8'hF0);
    step();
    check_val("a_pwm_lo", 32'(pwm_lo), 32'hF0);

    // A sets the lock; B is then granted but rejected; A can still write.
    set_a(7'h05, 8'h01);
    step();
    set_b(7'h04, 8'h55);
    step();
    check_val("locked_duty", 32'(duty), 32'(T_DEF_DUTY));
    set_a(7'h04, 8'h55);
    step();
    check_val("a_duty", 32'(duty), 32'h55);

    // A clears the lock; B writing the lock register and A writing an unmapped address both fail.
    set_a(7'h05, 8'h00);
    step();
    set_b(7'h05, 8'h01);
    step();
    set_a(7'h07, 8'hAA);
    step();
    check_val("unlock_lock", 32'(lock), 32'd0);

    // Reset during COMMIT discards the write and reloads the defaults.
    set_a(7'h00, 8'hFF);
    bus.a_valid = 1'b1; bus.a_addr = pa_addr; bus.a_data = pa_data;
    #1;
    check_val("rstc_a_ready", 32'(bus.a_ready), 32'd1);
    @(negedge clk);
    do_reset();

    // Randomized two-port traffic with one reset in the middle.
    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      if (!pa_v && $urandom_range(0, 9) < 6) rand_req(1'b0);
      if (!pb_v && $urandom_range(0, 9) < 6) rand_req(1'b1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
